sync_fifo: RTL



---
 rtl/fifo_pkg.sv | 37 +++
 rtl/sync_fifo_if.sv | 45 ++++
 rtl/dp_ram_sync.sv | 46 ++++
 rtl/sync_fifo.sv | 115 +++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared definitions for the synchronous FIFO slice:
//   - default data/address widths used by the interface and the FIFO
//   - clog2 helper for callers that size things from an entry count
//   - range checks for the almost-full / almost-empty thresholds
// No ports; imported by the interface and the design modules.
package fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_AF_TH  = 14;
  localparam int DEF_AE_TH  = 2;

  // Ceiling log2, returns 0 for values of 0 or 1.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  // almost_full must be reachable and must not be permanently on.
  function automatic bit af_th_ok(input int th, input int depth);
    return (th >= 1) && (th <= depth);
  endfunction

  // almost_empty must not be permanently on once the FIFO is full.
  function automatic bit ae_th_ok(input int th, input int depth);
    return (th >= 0) && (th <= depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// sync_fifo_if
// Bundles the producer/consumer handshake and status signals of sync_fifo.
//   master : the user side (drives wr_en/wr_data/rd_en, observes the rest)
//   slave  : the FIFO side (observes requests, drives data/status)
// Signals:
//   wr_en, wr_data          write request and data
//   rd_en                   read request
//   rd_data, rd_valid       registered read data and its one-cycle strobe
//   full, empty             occupancy limits
//   almost_full/empty       programmable threshold flags
//   count                   occupancy 0..DEPTH
//   overflow, underflow     sticky error flags
interface sync_fifo_if
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) ();

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/dp_ram_sync.sv
// dp_ram_sync
// Simple dual-port RAM on a single clock: one write port, one read port
// with a registered output. Contents are never reset; only the output
// register is cleared by rst so the FIFO presents a known rd_data.
// Ports:
//   clk, rst         clock and synchronous active-high reset (rdata only)
//   we, waddr, wdata write port
//   re, raddr        read port request/address
//   rdata            registered read data, holds when re is low
// A read and write to the same address in one cycle returns the old word.
module dp_ram_sync
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Output register: old-data semantics fall out of the non-blocking write.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo
// Single-clock FIFO on top of dp_ram_sync. Keeps ADDR_W+1 bit pointers
// whose MSB is a wrap bit, so occupancy is simply wr_ptr - rd_ptr and
// full/empty need no special casing. All status outputs are decoded from
// the registered pointers only.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  sync_fifo_if.slave (requests in, data/status/sticky errors out)
// Parameters:
//   DATA_W, ADDR_W  data width, address width (DEPTH = 2**ADDR_W)
//   AF_TH           almost_full when count >= AF_TH   (1..DEPTH)
//   AE_TH           almost_empty when count <= AE_TH  (0..DEPTH-1)
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int AF_TH  = DEF_AF_TH,
  parameter int AE_TH  = DEF_AE_TH
) (
  input logic       clk,
  input logic       rst,
  sync_fifo_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [ADDR_W:0] DEPTH_V = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] AF_V    = AF_TH[ADDR_W:0];
  localparam logic [ADDR_W:0] AE_V    = AE_TH[ADDR_W:0];
  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  if (!af_th_ok(AF_TH, DEPTH)) begin : g_af_range
    $error("sync_fifo: AF_TH must lie in 1..DEPTH");
  end
  if (!ae_th_ok(AE_TH, DEPTH)) begin : g_ae_range
    $error("sync_fifo: AE_TH must lie in 0..DEPTH-1");
  end

  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic [ADDR_W:0] count;
  logic            full;
  logic            empty;
  logic            wr_ok;
  logic            rd_ok;
  logic            rd_valid;
  logic            overflow;
  logic            underflow;

  // Occupancy wraps naturally modulo 2**(ADDR_W+1).
  assign count = wr_ptr - rd_ptr;
  assign full  = (count == DEPTH_V);
  assign empty = (count == '0);

  // Acceptance is gated by the registered flags, so a simultaneous
  // read while full frees nothing for the write in the same cycle.
  assign wr_ok = bus.wr_en && !full && !rst;
  assign rd_ok = bus.rd_en && !empty && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // rd_valid marks the cycle in which the RAM output register was loaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
    end
  end

  // Sticky errors: set on the first rejected request, cleared only by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (bus.wr_en && full)  overflow  <= 1'b1;
      if (bus.rd_en && empty) underflow <= 1'b1;
    end
  end

  dp_ram_sync #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (bus.wr_data),
    .re    (rd_ok),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (bus.rd_data)
  );

  assign bus.rd_valid     = rd_valid;
  assign bus.count        = count;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count >= AF_V);
  assign bus.almost_empty = (count <= AE_V);
  assign bus.overflow     = overflow;
  assign bus.underflow    = underflow;

endmodule
